// File: rtl/sum4_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the sequential operand summer.
// The derived sum width is computed here so the top and adder agree.
package sum4_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEF_W_IN  = 4;
    localparam int DEF_N_OPS = 4;

    function automatic int calc_w_out(input int w_in, input int n_ops);
        return w_in + $clog2(n_ops);
    endfunction

endpackage

// File: rtl/sum4_seq_ctrl_adder.sv
// The single shared adder: accumulator plus one zero-extended operand.
// Purely combinational; the sequencer owns all state.
module seq_acc_adder
    import sum4_seq_ctrl_pkg::*;
#(
    parameter int W_IN  = DEF_W_IN,
    parameter int W_OUT = calc_w_out(DEF_W_IN, DEF_N_OPS)
) (
    input  logic [W_OUT-1:0] i_acc,
    input  logic [W_IN-1:0]  i_op,
    output logic [W_OUT-1:0] o_sum
);

    assign o_sum = i_acc + W_OUT'(i_op);

endmodule

// File: rtl/sum4_seq_ctrl.sv
// Sums N_OPS captured operands one per cycle through a shared adder and
// hands the result off on a valid/ready port.
module sum4_seq_ctrl
    import sum4_seq_ctrl_pkg::*;
#(
    parameter int W_IN  = DEF_W_IN,
    parameter int N_OPS = DEF_N_OPS,
    parameter int W_OUT = calc_w_out(W_IN, N_OPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_OPS*W_IN-1:0] in_ops,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W_OUT-1:0]      out_sum,
    output logic                  busy,
    output logic [7:0]            job_cnt
);

    localparam int W_IDX = $clog2(N_OPS);
    localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_OPS - 1);

    if (W_OUT != calc_w_out(W_IN, N_OPS)) begin : g_bad_w_out
        $error("sum4_seq_ctrl: W_OUT must equal W_IN + clog2(N_OPS)");
    end

    state_t           r_state;
    logic [W_OUT-1:0] r_acc;
    logic [W_IDX-1:0] r_idx;
    logic [W_IN-1:0]  r_ops [N_OPS];
    logic [W_OUT-1:0] w_sum;

    seq_acc_adder #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_adder (
        .i_acc (r_acc),
        .i_op  (r_ops[r_idx]),
        .o_sum (w_sum)
    );

    // NOTE: the operand register is a datapath store that is always written
    // before it is read, so it carries no reset and stays a plain flop array.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid) begin
            for (int i = 0; i < N_OPS; i++) begin
                r_ops[i] <= in_ops[i*W_IN +: W_IN];
            end
        end
    end

    // NOTE: every register in this block uses non-blocking assignment so all
    // next-state values are computed from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            job_cnt   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state  <= S_ACCUM;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    // The last add lands directly in the output register.
                    if (r_idx == IDX_LAST) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        out_sum   <= w_sum;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        job_cnt   <= job_cnt + 8'd1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum4_seq_ctrl.sv
// Directed bench for sum4_seq_ctrl: reset, sums, backpressure, abort by
// reset, and job counter wrap.
module tb_sum4_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ops;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_sum;
    logic        busy;
    logic [7:0]  job_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_cnt;

    sum4_seq_ctrl #(
        .W_IN  (4),
        .N_OPS (4),
        .W_OUT (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .job_cnt   (job_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_job(input string tag, input logic [15:0] ops, input logic [5:0] exp_sum);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_ops    = ops;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_ops   = ~ops;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        tick();
        exp_cnt++;
        check({tag, "_handoff"}, 32'(out_valid), 32'd0);
        check({tag, "_cnt"}, 32'(job_cnt), 32'(exp_cnt));
    endtask

    function automatic logic [5:0] nib_sum(input logic [15:0] ops);
        logic [5:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + 6'(ops[k*4 +: 4]);
        return s;
    endfunction

    initial begin
        int         lat;
        logic [7:0] b;
        logic [15:0] ops;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ops    = '0;
        exp_cnt   = '0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_job_cnt",   32'(job_cnt),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Basic sums and boundaries
        run_job("seq_4321", 16'h4321, 6'd10);
        run_job("all_ones", 16'hFFFF, 6'd60);
        run_job("all_zero", 16'h0000, 6'd0);
        run_job("mixed",    16'h8F07, 6'd30);

        // Backpressure with a second job waiting
        in_valid  = 1'b1;
        in_ops    = 16'h5555;
        out_ready = 1'b0;
        tick();
        in_ops = 16'h1111;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        repeat (6) begin
            tick();
            check("bp_hold_sum",   32'(out_sum),   32'd20);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        check("bp_handoff",       32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready),  32'd1);
        check("bp_cnt",           32'(job_cnt),   32'(exp_cnt));
        tick();
        check("bp_second_accept", 32'(in_ready), 32'd0);
        check("bp_second_busy",   32'(busy),     32'd1);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_second_latency", 32'(lat),     32'd4);
        check("bp_second_sum",     32'(out_sum), 32'd4);
        tick();
        exp_cnt++;
        check("bp_second_cnt", 32'(job_cnt), 32'(exp_cnt));

        // Reset in the middle of accumulation
        in_valid = 1'b1;
        in_ops   = 16'h9999;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_job_cnt",   32'(job_cnt),   32'd0);
        check("abort_out_sum",   32'(out_sum),   32'd0);
        tick();
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_job("post_rst", 16'h1111, 6'd4);

        // Counter wrap over 256 back-to-back jobs
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 256; i++) begin
            b   = 8'(i);
            ops = {b[3:0], ~b[3:0], b[7:4], 4'h3};
            run_job("bulk", ops, nib_sum(ops));
            if (i == 254) check("cnt_255", 32'(job_cnt), 32'd255);
        end
        check("cnt_wrap", 32'(job_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
